// File: rtl/apb_mem_slave_if.sv
// Request/response bundle between the bus driver and the memory slave.
// The master drives the request and holds it until it sees ready.
interface apb_mem_slave_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (
    output valid,
    output wr_rd,
    output addr,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  valid,
    input  wr_rd,
    input  addr,
    input  wdata,
    output rdata,
    output ready
  );

  modport monitor (
    input valid,
    input wr_rd,
    input addr,
    input wdata,
    input rdata,
    input ready
  );
endinterface

// File: rtl/apb_mem_slave.sv
// Memory slave: accepts one request, waits WAIT_STATES cycles,
// then completes it with a single-cycle registered ready pulse.
module apb_mem_slave #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 2**ADDR_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input logic            clk,
  input logic            res,
  apb_mem_slave_if.slave bus
);

  localparam int IW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0] WS_LOAD =
    4'(WAIT_STATES - 1);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic                  accept;

  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;

  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  in_range;
  logic [IW-1:0]         idx;

  logic                  ready_q;
  logic                  ready_d;
  logic [WIDTH-1:0]      rdata_q;
  logic [WIDTH-1:0]      rdata_d;
  logic                  mem_we;

  logic [WIDTH-1:0]      mem [DEPTH];

  // In IDLE the live bus is the request; afterwards the latched copy.
  assign req_wr   = accept ? bus.wr_rd : wr_q;
  assign req_addr = accept ? bus.addr  : addr_q;
  assign in_range = {1'b0, req_addr} < DEPTH_L;
  assign idx      = req_addr[IW-1:0];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.wr_rd;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          accept = 1'b1;
          if (NO_WAIT) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!bus.valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == S_ACCESS);
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    if (state_d == S_ACCESS && !req_wr) begin
      rdata_d = in_range ? mem[idx] : '0;
    end
    // The write lands on the edge that leaves ACCESS.
    if (state_q == S_ACCESS && wr_q && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  ready_single_a: assert property (
    @(posedge clk) disable iff (!res)
    ready_q |=> !ready_q
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: four instances cover the
// wait-state variants and a shallow memory for range checks.
module tb_apb_mem_slave;

  logic clk;
  logic res;

  int checks = 0;
  int errors = 0;

  apb_mem_slave_if #(.WIDTH(32), .ADDR_WIDTH(8)) i0 ();
  apb_mem_slave_if #(.WIDTH(32), .ADDR_WIDTH(8)) i1 ();
  apb_mem_slave_if #(.WIDTH(32), .ADDR_WIDTH(8)) i2 ();
  apb_mem_slave_if #(.WIDTH(32), .ADDR_WIDTH(8)) i5 ();

  apb_mem_slave #(
    .WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)
  ) d0 (.clk(clk), .res(res), .bus(i0));

  apb_mem_slave #(
    .WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(1)
  ) d1 (.clk(clk), .res(res), .bus(i1));

  apb_mem_slave #(
    .WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)
  ) d2 (.clk(clk), .res(res), .bus(i2));

  apb_mem_slave #(
    .WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16),
    .WAIT_STATES(5)
  ) d5 (.clk(clk), .res(res), .bus(i5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          sel;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    int          lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input int s, input logic w, input logic [7:0] a,
    input logic [31:0] d, input int lat,
    input logic [31:0] e
  );
    vec_t v;
    v.sel = s; v.wr = w; v.a = a; v.d = d;
    v.lat = lat; v.exp_rd = e;
    return v;
  endfunction

  task automatic chk(
    input string name, input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input int s, input logic v, input logic w,
    input logic [7:0] a, input logic [31:0] d
  );
    case (s)
      0: begin
        i0.valid = v; i0.wr_rd = w;
        i0.addr = a; i0.wdata = d;
      end
      1: begin
        i1.valid = v; i1.wr_rd = w;
        i1.addr = a; i1.wdata = d;
      end
      5: begin
        i5.valid = v; i5.wr_rd = w;
        i5.addr = a; i5.wdata = d;
      end
      default: begin
        i2.valid = v; i2.wr_rd = w;
        i2.addr = a; i2.wdata = d;
      end
    endcase
  endtask

  function automatic logic get_ready(input int s);
    case (s)
      0:       return i0.ready;
      1:       return i1.ready;
      5:       return i5.ready;
      default: return i2.ready;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int s);
    case (s)
      0:       return i0.rdata;
      1:       return i1.rdata;
      5:       return i5.rdata;
      default: return i2.rdata;
    endcase
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic xfer(input vec_t v, input string tag);
    int          lat;
    logic        got;
    logic [31:0] rd;
    lat = 0;
    got = 1'b0;
    drive(v.sel, 1'b1, v.wr, v.a, v.d);
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (get_ready(v.sel)) got = 1'b1;
    end
    rd = get_rdata(v.sel);
    drive(v.sel, 1'b0, 1'b0, 8'h00, 32'h0);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ready in 40 edges",
               tag);
    end else begin
      chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
      chk({tag, "_rdata"}, rd, v.exp_rd);
    end
    @(negedge clk);
    chk({tag, "_width"}, 32'(get_ready(v.sel)), 32'd0);
  endtask

  initial begin
    int          k;
    int          c;
    int          n;
    int          pulse [4];
    vec_t        v;

    res = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(2, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(5, 1'b0, 1'b0, 8'h00, 32'h0);
    #2 res = 1'b0;
    #1;
    chk("rst_ready", 32'(i2.ready), 32'd0);
    chk("rst_rdata", i2.rdata, 32'h0);
    chk("rst_ready_ws0", 32'(i0.ready), 32'd0);
    chk("rst_rdata_ws5", i5.rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;

    // WAIT_STATES=2, full depth
    tbl.push_back(mk(2, 1, 8'h10, 32'hDEADBEEF, 3, 32'h0));
    tbl.push_back(mk(2, 0, 8'h10, 32'h0, 3, 32'hDEADBEEF));
    tbl.push_back(mk(2, 1, 8'hFF, 32'h00000001, 3,
                     32'hDEADBEEF));
    tbl.push_back(mk(2, 0, 8'hFF, 32'h0, 3, 32'h00000001));
    tbl.push_back(mk(2, 0, 8'h11, 32'h0, 3, 32'h0));
    tbl.push_back(mk(2, 1, 8'h00, 32'hCAFEF00D, 3, 32'h0));
    tbl.push_back(mk(2, 0, 8'h00, 32'h0, 3, 32'hCAFEF00D));
    tbl.push_back(mk(2, 1, 8'h10, 32'h12345678, 3,
                     32'hCAFEF00D));
    tbl.push_back(mk(2, 0, 8'h10, 32'h0, 3, 32'h12345678));
    // latency sweep
    tbl.push_back(mk(0, 0, 8'h03, 32'h0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 8'h07, 32'h77, 1, 32'h0));
    tbl.push_back(mk(0, 0, 8'h07, 32'h0, 1, 32'h77));
    tbl.push_back(mk(1, 0, 8'h03, 32'h0, 2, 32'h0));
    tbl.push_back(mk(1, 1, 8'h04, 32'h44, 2, 32'h0));
    tbl.push_back(mk(1, 0, 8'h04, 32'h0, 2, 32'h44));
    tbl.push_back(mk(5, 0, 8'h03, 32'h0, 6, 32'h0));
    // DEPTH=16: 0x30 and 0x10 alias word 0 if unchecked
    tbl.push_back(mk(5, 1, 8'h00, 32'hAB, 6, 32'h0));
    tbl.push_back(mk(5, 0, 8'h00, 32'h0, 6, 32'hAB));
    tbl.push_back(mk(5, 1, 8'h30, 32'h55, 6, 32'hAB));
    tbl.push_back(mk(5, 0, 8'h30, 32'h0, 6, 32'h0));
    tbl.push_back(mk(5, 0, 8'h00, 32'h0, 6, 32'hAB));
    tbl.push_back(mk(5, 1, 8'h0F, 32'h5A, 6, 32'hAB));
    tbl.push_back(mk(5, 0, 8'h10, 32'h0, 6, 32'h0));
    tbl.push_back(mk(5, 0, 8'h0F, 32'h0, 6, 32'h5A));

    foreach (tbl[i]) begin
      xfer(tbl[i], $sformatf("vec%0d", i));
    end

    // abort a write after one WAIT cycle
    drive(2, 1'b1, 1'b1, 8'h05, 32'h1234);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 8'h00, 32'h0);
    n = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (i2.ready) n++;
    end
    chk("abort_no_ready", 32'(n), 32'd0);
    chk("abort_rdata_hold", i2.rdata, 32'h12345678);
    v = mk(2, 0, 8'h05, 32'h0, 3, 32'h0);
    xfer(v, "abort_read");

    // back-to-back writes with valid held high
    k = 0;
    c = 0;
    drive(2, 1'b1, 1'b1, 8'h00, 32'hA0);
    while (c < 40) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (i2.ready) begin
        if (k < 4) pulse[k] = c;
        k++;
        if (k < 4) begin
          drive(2, 1'b1, 1'b1, 8'(k), 32'hA0 + 32'(k));
        end else begin
          drive(2, 1'b0, 1'b0, 8'h00, 32'h0);
        end
      end
    end
    chk("b2b_count", 32'(k), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_edge%0d", i),
          32'(pulse[i]), 32'(3 + 4 * i));
    end
    for (int i = 0; i < 4; i++) begin
      v = mk(2, 0, 8'(i), 32'h0, 3, 32'hA0 + 32'(i));
      xfer(v, $sformatf("b2b_rd%0d", i));
    end

    // reset during WAIT of a write
    drive(2, 1'b1, 1'b1, 8'h20, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("midrst_ready", 32'(i2.ready), 32'd0);
    chk("midrst_rdata", i2.rdata, 32'h0);
    chk("midrst_rdata_ws5", i5.rdata, 32'h0);
    drive(2, 1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    v = mk(2, 0, 8'h20, 32'h0, 3, 32'h0);
    xfer(v, "midrst_rd20");
    v = mk(2, 0, 8'h10, 32'h0, 3, 32'h0);
    xfer(v, "midrst_rd10");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parameterised memory slave that consumes the valid/ready request interface driven by the bus driver: it accepts single write or read requests, inserts a programmable number of wait states, then completes the transfer with a one-cycle `ready` pulse. It is the design endpoint that sits directly downstream of the request interface and is the DUT that the driver and monitor clocking blocks attach to.

## Interface
- `WIDTH`, default 32: data width in bits.
- `ADDR_WIDTH`, default 8: address width in bits.
- `DEPTH`, default 2**ADDR_WIDTH: number of words implemented; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- `WAIT_STATES`, default 2: wait cycles inserted between request acceptance and completion; legal range 0..15.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `res`, input, 1: reset, asynchronous, active-low.
- `valid`, input, 1: request present.
- `wr_rd`, input, 1: 1 = write, 0 = read.
- `addr`, input, ADDR_WIDTH: word address.
- `wdata`, input, WIDTH: write data.
- `rdata`, output, WIDTH: read data, registered.
- `ready`, output, 1: transfer completion, registered, high for exactly one cycle per completed transfer.

## Operation
- Reset (`res`=0): state IDLE, wait counter 0, `ready`=0, `rdata`=0, and all DEPTH words cleared to 0. Reset takes effect immediately, independent of `clk`.
- States:
  - IDLE: `ready`=0. If `valid`=1 at a rising edge, latch `wr_rd`, `addr` and `wdata`, then go to WAIT with counter = WAIT_STATES-1. If WAIT_STATES=0, go directly to ACCESS.
  - WAIT: `ready`=0. Each edge decrements the counter; the state moves to ACCESS on the edge where the counter is 0.
  - ACCESS: `ready`=1 for this cycle. For a read, `rdata` was loaded on the edge that entered ACCESS. For a write, the word is committed on the edge that leaves ACCESS. The next state is always IDLE.
- The master holds `valid`, `wr_rd`, `addr` and `wdata` stable from assertion until it samples `ready`=1. The slave operates on the values latched in IDLE; changes to the inputs after acceptance are ignored.
- Abort: if `valid`=0 at any edge while in WAIT, return to IDLE. There is no write, `rdata` is unchanged and `ready` never rises.
- Out of range (addr ≥ DEPTH): a write is completed with `ready` but memory is unchanged; a read completes with `rdata`=0.
- `rdata` holds the last read value through writes, idle cycles and aborts. It changes only on entry to ACCESS for a read.
- Read after write to the same address returns the new data. The write commits before the next transfer can reach ACCESS.

## Timing
- Request sampled at edge N (state IDLE): `ready`=1 during the cycle after edge N+WAIT_STATES, i.e. request-to-ready latency is WAIT_STATES+1 edges.
- Minimum transfer period is WAIT_STATES+2 cycles: IDLE, WAIT_STATES×WAIT, ACCESS.
- With `valid` held high continuously, the IDLE cycle after ACCESS re-samples it and starts a new transfer. `ready` is therefore never high on two consecutive cycles.
- Outputs change only just after a rising `clk` edge or on reset assertion. There is no combinational path from any input to `ready` or `rdata`.
- Reset asserted mid-transfer aborts it with no write. Outputs return to their reset values immediately. The first request is accepted at the first rising edge after `res` deasserts.

## Test plan
- Write then read, WAIT_STATES=2: write 0xDEADBEEF to addr 0x10, then read 0x10 → `ready` pulses 3 edges after each request; `rdata`=0xDEADBEEF during the read's ready cycle.
- Latency sweep over WAIT_STATES ∈ {0,1,5}: single read → `ready` after 1, 2 and 6 edges respectively, width 1 cycle.
- Abort: drop `valid` after one WAIT cycle of a write of 0x1234 to 0x05, then read 0x05 → no `ready` for the aborted write; read returns 0.
- Back-to-back: `valid` held high for 4 writes to addresses 0..3, data 0xA0..0xA3 → exactly 4 `ready` pulses, spaced WAIT_STATES+2 cycles apart; readback matches.
- Reset mid-transfer: assert `res` during WAIT of a write of 0xFFFF_FFFF to 0x20 → `ready`=0 and `rdata`=0 immediately; after release, a read of 0x20 returns 0.
- Out of range, DEPTH=16: write 0x55 to addr 0x30, then read 0x30 → both complete with `ready`; `rdata`=0, and addr 0x00 is unchanged.
